// File: rtl/mips_cpu_alu_registers.sv
// mips_cpu_alu_registers: 32x32 register file with $v0 tap and combinational MIPS32 ALU.
module mips_cpu_alu_registers (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr_a,
    output logic [31:0] rd_data_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_b,
    output logic [31:0] register_v0,
    input  logic [4:0]  alu_op,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [4:0]  alu_sa,
    output logic [31:0] alu_result,
    output logic        alu_zero
);
    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_write && wr_addr != 5'd0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // $zero is forced on the read side so its storage content never matters
    assign rd_data_a   = (rd_addr_a == 5'd0) ? '0 : regs[rd_addr_a];
    assign rd_data_b   = (rd_addr_b == 5'd0) ? '0 : regs[rd_addr_b];
    assign register_v0 = regs[2];

    always_comb begin
        alu_result = '0;
        case (alu_op)
            5'd0:  alu_result = alu_a & alu_b;
            5'd1:  alu_result = alu_a | alu_b;
            5'd2:  alu_result = alu_a + alu_b;
            5'd3:  alu_result = alu_a - alu_b;
            5'd4:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            5'd5:  alu_result = alu_a ^ alu_b;
            5'd6:  alu_result = alu_b << alu_sa;
            5'd7:  alu_result = alu_b >> alu_sa;
            5'd8:  alu_result = $signed(alu_b) >>> alu_sa;
            5'd9:  alu_result = alu_b << alu_a[4:0];
            5'd10: alu_result = alu_b >> alu_a[4:0];
            5'd11: alu_result = $signed(alu_b) >>> alu_a[4:0];
            5'd12: alu_result = {alu_b[15:0], 16'h0000};
            default: alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == '0);
endmodule

// File: tb/tb_mips_cpu_alu_registers.sv
// tb_mips_cpu_alu_registers: directed plan plus random regfile/ALU traffic against a behavioural model.
module tb_mips_cpu_alu_registers;
    logic        clk = 0;
    logic        rst, reg_write;
    logic [4:0]  wr_addr, rd_addr_a, rd_addr_b, alu_op, alu_sa;
    logic [31:0] wr_data, rd_data_a, rd_data_b, register_v0, alu_a, alu_b, alu_result;
    logic        alu_zero;
    int          checks = 0, errors = 0;
    logic [31:0] model [32];

    mips_cpu_alu_registers dut (
        .clk(clk), .rst(rst), .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .register_v0(register_v0), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_sa(alu_sa),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input int op, input logic [31:0] a, input logic [31:0] b, input int s);
        logic [31:0] fill;
        fill = b[31] ? ~(32'hFFFFFFFF >> s) : 32'h0;
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a + b;
            3: return a + ~b + 1;
            4: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5: return a ^ b;
            6, 9: return b << s;
            7, 10: return b >> s;
            8, 11: return (b >> s) | fill;
            12: return (b & 32'hFFFF) * 32'h10000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic alu_run(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                           input int sa, input logic [31:0] exp);
        alu_op = op[4:0]; alu_a = a; alu_b = b; alu_sa = sa[4:0];
        #1;
        check(tag, alu_result, exp);
        check({tag, "_zero"}, {31'd0, alu_zero}, {31'd0, exp == 0});
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = i[4:0]; rd_addr_b = 5'(31 - i);
            #1;
            check({tag, "_a"}, rd_data_a, model[i]);
            check({tag, "_b"}, rd_data_b, model[31 - i]);
        end
        check({tag, "_v0"}, register_v0, model[2]);
    endtask

    initial begin
        rst = 1; reg_write = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        rd_addr_a = 0; rd_addr_b = 0; alu_op = 0; alu_a = 0; alu_b = 0; alu_sa = 0;
        @(posedge clk); #1;
        rst = 0; reg_write = 0;
        for (int i = 0; i < 32; i++) model[i] = 0;
        read_all("reset");

        reg_write = 1; wr_addr = 2; wr_data = 32'h12345678; rd_addr_a = 2;
        #1 check("no_bypass", rd_data_a, 32'h0);
        @(posedge clk); #1;
        model[2] = 32'h12345678;
        check("v0_write", register_v0, 32'h12345678);
        check("porta_after", rd_data_a, 32'h12345678);
        wr_addr = 0; wr_data = 32'hFFFFFFFF; rd_addr_b = 0;
        @(posedge clk); #1;
        reg_write = 0;
        check("r0_write", rd_data_b, 32'h0);

        alu_run("add_wrap", 2, 32'hFFFFFFFF, 1, 0, 32'h0);
        alu_run("sub", 3, 5, 7, 0, 32'hFFFFFFFE);
        alu_run("slt_neg", 4, 32'hFFFFFFFF, 1, 0, 32'h1);
        alu_run("slt_pos", 4, 1, 32'hFFFFFFFF, 0, 32'h0);
        alu_run("and", 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h00F000F0);
        alu_run("or", 1, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'hFFF0FFF0);
        alu_run("xor", 5, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'hFF00FF00);
        alu_run("lui", 12, 32'h0, 32'hFFFF1234, 0, 32'h12340000);
        alu_run("sll", 6, 32'h0, 32'h1, 31, 32'h80000000);
        alu_run("srl", 7, 32'h0, 32'h80000000, 4, 32'h08000000);
        alu_run("sra", 8, 32'h0, 32'h80000000, 4, 32'hF8000000);
        alu_run("srav", 11, 32'h00000024, 32'h80000000, 0, 32'hF8000000);
        alu_run("sllv0", 9, 32'h0, 32'hA5A5A5A5, 7, 32'hA5A5A5A5);
        alu_run("srlv_hi", 10, 32'hFFFFFFE3, 32'h80000000, 0, 32'h10000000);
        alu_run("undef13", 13, 32'h12345678, 32'h9ABCDEF0, 5, 32'h0);
        alu_run("undef31", 31, 32'hFFFFFFFF, 32'hFFFFFFFF, 31, 32'h0);

        for (int n = 0; n < 400; n++) begin
            int op, s;
            logic [31:0] a, b;
            reg_write = 1'($urandom);
            wr_addr = 5'($urandom); wr_data = $urandom;
            rd_addr_a = 5'($urandom); rd_addr_b = (n % 5 == 0) ? rd_addr_a : 5'($urandom);
            if (n % 7 == 0) rd_addr_a = wr_addr;
            #1;
            check("rnd_rd_a", rd_data_a, model[rd_addr_a]);
            check("rnd_rd_b", rd_data_b, model[rd_addr_b]);
            op = $urandom_range(0, 15); a = $urandom; b = $urandom; s = $urandom_range(0, 31);
            if (op == 4 && n % 3 == 0) b = a;
            alu_run("rnd_alu", op, a, b, s, alu_model(op, a, b, (op >= 9 && op <= 11) ? int'(a % 32) : s));
            @(posedge clk); #1;
            if (reg_write && wr_addr != 0) model[wr_addr] = wr_data;
            check("rnd_v0", register_v0, model[2]);
        end
        reg_write = 0;
        read_all("pre_rst");

        rst = 1; reg_write = 1; wr_addr = 7; wr_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 0; reg_write = 0;
        for (int i = 0; i < 32; i++) model[i] = 0;
        read_all("mid_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
